aes_key_schedule_seq: RTL and testbench



---
 rtl/aes_pkg.sv | 79 +++++++
 rtl/aes_key_schedule_seq_if.sv | 35 +++
 rtl/aes_sbox_word.sv | 19 +
 rtl/aes_key_schedule_seq.sv | 218 +++++++++++++++++++++
 tb/tb_aes_key_schedule_seq.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions for the key scheduler and the cipher rounds.
//   - key_len encodings (128 / 192 / 256 / illegal)
//   - scheduler FSM state type and the round-key FIFO entry struct
//   - Nk / Nr / key-size lookups derived from key_len
//   - xtime (multiply by x in GF(2^8)) used to step Rcon
//   - the forward S-box table, byte 0x00 stored in the top byte
// ---------------------------------------------------------------------------
package aes_pkg;

   localparam logic [1:0] KEY_LEN_128     = 2'd0;
   localparam logic [1:0] KEY_LEN_192     = 2'd1;
   localparam logic [1:0] KEY_LEN_256     = 2'd2;
   localparam logic [1:0] KEY_LEN_ILLEGAL = 2'd3;

   typedef enum logic [1:0] {
      IDLE,
      GEN,
      DRAIN
   } schedStateT;

   typedef struct packed {
      logic [127:0] data;
      logic [3:0]   index;
      logic         last;
   } roundKeyT;

   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Number of 32-bit words in the cipher key.
   function automatic logic [3:0] nkOf(input logic [1:0] keyLen);
      case (keyLen)
         KEY_LEN_128: return 4'd4;
         KEY_LEN_192: return 4'd6;
         default:     return 4'd8;
      endcase
   endfunction

   // Number of cipher rounds; the schedule emits Nr+1 round keys.
   function automatic logic [3:0] nrOf(input logic [1:0] keyLen);
      case (keyLen)
         KEY_LEN_128: return 4'd10;
         KEY_LEN_192: return 4'd12;
         default:     return 4'd14;
      endcase
   endfunction

   // Key size in bits; the illegal code maps above any supported size.
   function automatic int keyBitsOf(input logic [1:0] keyLen);
      return 128 + 64 * int'(keyLen);
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TABLE[(255 - int'(b)) * 8 +: 8];
   endfunction

endpackage

// File: rtl/aes_key_schedule_seq_if.sv
// ---------------------------------------------------------------------------
// aes_key_schedule_seq_if
// Round-key stream between the key scheduler (master) and the cipher round
// pipeline (slave).
//   rk_valid  master->slave  head of the round-key FIFO is valid
//   rk_ready  slave->master  consumer takes the head this cycle
//   rk_data   master->slave  round key, w[4r] in [127:96]
//   rk_index  master->slave  round number r
//   rk_last   master->slave  high on the final round key
// ---------------------------------------------------------------------------
interface aes_key_schedule_seq_if;

   logic         rk_valid;
   logic         rk_ready;
   logic [127:0] rk_data;
   logic [3:0]   rk_index;
   logic         rk_last;

   modport master (
      output rk_valid,
      output rk_data,
      output rk_index,
      output rk_last,
      input  rk_ready
   );

   modport slave (
      input  rk_valid,
      input  rk_data,
      input  rk_index,
      input  rk_last,
      output rk_ready
   );

endinterface

// File: rtl/aes_sbox_word.sv
// ---------------------------------------------------------------------------
// aes_sbox_word
// SubWord: four parallel forward S-boxes on a 32-bit word.
//   word     in   32  input word
//   subWord  out  32  S-box applied to each byte
// ---------------------------------------------------------------------------
module aes_sbox_word
   import aes_pkg::*;
(
   input  logic [31:0] word,
   output logic [31:0] subWord
);

   // Each byte lane is looked up independently; no mixing between lanes.
   for (genvar k = 0; k < 4; k++) begin : gLane
      assign subWord[8*k +: 8] = sbox(word[8*k +: 8]);
   end

endmodule

// File: rtl/aes_key_schedule_seq.sv
// ---------------------------------------------------------------------------
// aes_key_schedule_seq
// Sequential AES-128/192/256 key expansion, one 32-bit word per cycle through
// a single shared SubWord, streaming 128-bit round keys through a small FIFO.
//   clk      in   1    clock, rising edge
//   rst_n    in   1    asynchronous active-low reset
//   start    in   1    begin expansion (sampled only in IDLE)
//   key_len  in   2    0=AES-128, 1=AES-192, 2=AES-256, 3=illegal
//   key_in   in   256  cipher key, MSB-aligned
//   abort    in   1    synchronous flush back to IDLE
//   busy     out  1    expansion in progress or round keys still queued
//   err      out  1    one-cycle pulse on a rejected start
//   rk       master    round-key stream (valid/ready, data, index, last)
// ---------------------------------------------------------------------------
module aes_key_schedule_seq
   import aes_pkg::*;
#(
   parameter int MAX_KEY_BITS   = 256,
   parameter int OUT_FIFO_DEPTH = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic [1:0]                    key_len,
   input  logic [255:0]                  key_in,
   input  logic                          abort,
   output logic                          busy,
   output logic                          err,
   aes_key_schedule_seq_if.master        rk
);

   localparam int PTR_W = (OUT_FIFO_DEPTH > 1) ? $clog2(OUT_FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(OUT_FIFO_DEPTH + 1);
   localparam int MEM_N = 1 << PTR_W;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OUT_FIFO_DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUT_FIFO_DEPTH);

   schedStateT   state;
   logic [1:0]   keyLenQ;
   logic [255:0] keyQ;
   logic [5:0]   wordCnt;
   logic [2:0]   modCnt;
   logic [7:0]   rcon;
   logic [31:0]  win [8];
   logic [95:0]  groupQ;

   roundKeyT         fifoMem [MEM_N];
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;
   logic [CNT_W-1:0] fifoCnt;

   logic [3:0]  nk;
   logic [3:0]  nr;
   logic [31:0] keyWords [8];
   logic [31:0] prevWord;
   logic [31:0] farWord;
   logic [31:0] sboxIn;
   logic [31:0] sboxOut;
   logic [31:0] newWord;
   logic        inKey;
   logic        groupDone;
   logic        isLast;
   logic        fifoFull;
   logic        popFire;
   logic        genStep;
   logic        pushFire;
   logic        startLegal;

   assign nk = nkOf(keyLenQ);
   assign nr = nrOf(keyLenQ);

   assign startLegal = (key_len != KEY_LEN_ILLEGAL) && (keyBitsOf(key_len) <= MAX_KEY_BITS);

   aes_sbox_word uSboxWord (
      .word    (sboxIn),
      .subWord (sboxOut)
   );

   // Word generator. win[0] is w[i-1] and win[Nk-1] is w[i-Nk], so the
   // recurrence only needs the newest and the oldest word of the window.
   // RotWord is applied ahead of the shared S-box only on the i mod Nk == 0
   // step; the AES-256 mid-key step feeds the unrotated word.
   always_comb begin
      for (int k = 0; k < 8; k++) begin
         keyWords[k] = keyQ[255 - 32*k -: 32];
      end
      prevWord  = win[0];
      farWord   = win[3'(nk - 4'd1)];
      inKey     = (wordCnt < {2'b00, nk});
      sboxIn    = (modCnt == 3'd0) ? {prevWord[23:0], prevWord[31:24]} : prevWord;
      groupDone = (wordCnt[1:0] == 2'b11);
      isLast    = (wordCnt == {nr, 2'b11});
      newWord   = farWord ^ prevWord;
      if (inKey) begin
         newWord = keyWords[wordCnt[2:0]];
      end else if (modCnt == 3'd0) begin
         newWord = farWord ^ sboxOut ^ {rcon, 24'h000000};
      end else if ((nk == 4'd8) && (modCnt == 3'd4)) begin
         newWord = farWord ^ sboxOut;
      end
   end

   // Flow control. The generator only ever waits on the word that completes
   // a group; a pop in the same cycle frees the slot the push needs.
   always_comb begin
      fifoFull = (fifoCnt == FULL_CNT);
      popFire  = (fifoCnt != '0) && rk.rk_ready;
      genStep  = (state == GEN) && (!groupDone || !fifoFull || popFire);
      pushFire = genStep && groupDone;
   end

   // Scheduler FSM. Abort wins over everything; err is a one-cycle pulse;
   // busy drops on the edge that pops the final round key out of the FIFO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         busy    <= 1'b0;
         err     <= 1'b0;
         keyLenQ <= KEY_LEN_128;
         keyQ    <= '0;
         wordCnt <= '0;
         modCnt  <= '0;
         rcon    <= 8'h01;
         groupQ  <= '0;
         for (int k = 0; k < 8; k++) begin
            win[k] <= '0;
         end
      end else if (abort) begin
         state <= IDLE;
         busy  <= 1'b0;
         err   <= 1'b0;
      end else begin
         err <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (startLegal) begin
                     keyLenQ <= key_len;
                     keyQ    <= key_in;
                     wordCnt <= '0;
                     modCnt  <= '0;
                     rcon    <= 8'h01;
                     busy    <= 1'b1;
                     state   <= GEN;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            GEN: begin
               if (genStep) begin
                  win[0] <= newWord;
                  for (int k = 1; k < 8; k++) begin
                     win[k] <= win[k-1];
                  end
                  groupQ  <= {groupQ[63:0], newWord};
                  wordCnt <= wordCnt + 6'd1;
                  modCnt  <= (modCnt == 3'(nk - 4'd1)) ? 3'd0 : modCnt + 3'd1;
                  if (!inKey && (modCnt == 3'd0)) begin
                     rcon <= xtime(rcon);
                  end
                  if (pushFire && isLast) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if ((fifoCnt == '0) || ((fifoCnt == CNT_W'(1)) && popFire)) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Round-key FIFO. The array is sized to a power of two so the pointers
   // always index it in range; pointers wrap at the configured depth.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr   <= '0;
         rdPtr   <= '0;
         fifoCnt <= '0;
         for (int k = 0; k < MEM_N; k++) begin
            fifoMem[k] <= '0;
         end
      end else if (abort) begin
         wrPtr   <= '0;
         rdPtr   <= '0;
         fifoCnt <= '0;
      end else begin
         if (pushFire) begin
            fifoMem[wrPtr] <= '{data: {groupQ, newWord}, index: wordCnt[5:2], last: isLast};
            wrPtr          <= (wrPtr == LAST_PTR) ? '0 : wrPtr + PTR_W'(1);
         end
         if (popFire) begin
            rdPtr <= (rdPtr == LAST_PTR) ? '0 : rdPtr + PTR_W'(1);
         end
         if (pushFire && !popFire) begin
            fifoCnt <= fifoCnt + CNT_W'(1);
         end else if (!pushFire && popFire) begin
            fifoCnt <= fifoCnt - CNT_W'(1);
         end
      end
   end

   // Stream outputs come straight from the FIFO head registers.
   always_comb begin
      rk.rk_valid = (fifoCnt != '0);
      rk.rk_data  = fifoMem[rdPtr].data;
      rk.rk_index = fifoMem[rdPtr].index;
      rk.rk_last  = fifoMem[rdPtr].last;
   end

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// ---------------------------------------------------------------------------
// tb_aes_key_schedule_seq
// Directed bench for the sequential key scheduler. Instance A uses the full
// key range with a 2-entry FIFO, instance B is limited to 128-bit keys with a
// 1-entry FIFO. Expected round keys are the FIPS-197 expansion vectors.
// ---------------------------------------------------------------------------
module tb_aes_key_schedule_seq;
   import aes_pkg::*;

   localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
   localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   localparam logic [127:0] EXP128 [11] = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f,
      128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00,
      128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd,
      128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f,
      128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6
   };

   logic clk = 1'b0;
   logic rst_n;
   logic startA, abortA, busyA, errA;
   logic startB, abortB, busyB, errB;
   logic [1:0]   keyLenA, keyLenB;
   logic [255:0] keyA, keyB;
   bit randReadyA, randReadyB;

   int checkCount  = 0;
   int errorCount  = 0;

   logic [127:0] beatsA [$];
   logic [3:0]   idxA   [$];
   logic         lastA  [$];
   logic [127:0] beatsB [$];
   logic [3:0]   idxB   [$];
   logic         lastB  [$];
   logic         stallA = 1'b0, stallB = 1'b0;
   logic [132:0] holdA, holdB;

   aes_key_schedule_seq_if rkA ();
   aes_key_schedule_seq_if rkB ();

   aes_key_schedule_seq #(.MAX_KEY_BITS(256), .OUT_FIFO_DEPTH(2)) dutA (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (startA),
      .key_len (keyLenA),
      .key_in  (keyA),
      .abort   (abortA),
      .busy    (busyA),
      .err     (errA),
      .rk      (rkA)
   );

   aes_key_schedule_seq #(.MAX_KEY_BITS(128), .OUT_FIFO_DEPTH(1)) dutB (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (startB),
      .key_len (keyLenB),
      .key_in  (keyB),
      .abort   (abortB),
      .busy    (busyB),
      .err     (errB),
      .rk      (rkB)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
      checkCount++;
      assert (observed === expected)
      else begin
         errorCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Ready generators: always-ready, or roughly 30% duty when randomised.
   initial begin
      rkA.rk_ready = 1'b1;
      rkB.rk_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         rkA.rk_ready = randReadyA ? ($urandom_range(0, 9) < 3) : 1'b1;
         rkB.rk_ready = randReadyB ? ($urandom_range(0, 9) < 3) : 1'b1;
      end
   end

   // Stream monitors: capture accepted beats, and require the head to hold
   // still across every cycle it was offered but not taken.
   always @(negedge clk) begin
      if (stallA && rst_n) begin
         checkOutput("holdA", {rkA.rk_valid, rkA.rk_data, rkA.rk_index, rkA.rk_last}, {1'b1, holdA});
      end
      if (rkA.rk_valid && rkA.rk_ready) begin
         beatsA.push_back(rkA.rk_data);
         idxA.push_back(rkA.rk_index);
         lastA.push_back(rkA.rk_last);
      end
      stallA = rkA.rk_valid && !rkA.rk_ready;
      holdA  = {rkA.rk_data, rkA.rk_index, rkA.rk_last};
   end

   always @(negedge clk) begin
      if (stallB && rst_n) begin
         checkOutput("holdB", {rkB.rk_valid, rkB.rk_data, rkB.rk_index, rkB.rk_last}, {1'b1, holdB});
      end
      if (rkB.rk_valid && rkB.rk_ready) begin
         beatsB.push_back(rkB.rk_data);
         idxB.push_back(rkB.rk_index);
         lastB.push_back(rkB.rk_last);
      end
      stallB = rkB.rk_valid && !rkB.rk_ready;
      holdB  = {rkB.rk_data, rkB.rk_index, rkB.rk_last};
   end

   function automatic logic [127:0] beatA(input int k);
      return (k < beatsA.size()) ? beatsA[k] : 128'h0;
   endfunction

   task automatic clearBeats();
      beatsA.delete(); idxA.delete(); lastA.delete();
      beatsB.delete(); idxB.delete(); lastB.delete();
   endtask

   // One-cycle start pulse; returns #1 after the edge that sampled it.
   task automatic applyStimulus(input bit useB, input logic [1:0] len, input logic [255:0] key);
      if (useB) begin
         startB = 1'b1; keyLenB = len; keyB = key;
      end else begin
         startA = 1'b1; keyLenA = len; keyA = key;
      end
      @(posedge clk);
      #1;
      startA = 1'b0;
      startB = 1'b0;
   endtask

   // Run until busy drops, noting the edge counts of the first valid beat
   // and of the last beat. pokeAt injects a start while busy on instance A.
   task automatic runUntilIdle(input bit useB, input int bound, input int pokeAt,
                               output int firstValid, output int lastAt, output int idleAt);
      logic v, l, b;
      firstValid = -1;
      lastAt     = -1;
      idleAt     = -1;
      for (int n = 1; n <= bound; n++) begin
         @(posedge clk);
         #1;
         v = useB ? rkB.rk_valid : rkA.rk_valid;
         l = useB ? rkB.rk_last  : rkA.rk_last;
         b = useB ? busyB : busyA;
         if (v && firstValid < 0) firstValid = n;
         if (v && l && lastAt < 0) lastAt = n;
         if (!b) begin
            idleAt = n;
            break;
         end
         if (n == pokeAt) begin
            startA = 1'b1; keyLenA = KEY_LEN_256; keyA = KEY256;
         end else begin
            startA = 1'b0;
         end
      end
      startA = 1'b0;
      checkOutput(useB ? "idleB" : "idleA", useB ? busyB : busyA, 1'b0);
   endtask

   task automatic checkBeats128(input bit useB, input string pfx);
      int n;
      n = useB ? beatsB.size() : beatsA.size();
      checkOutput({pfx, "_count"}, n, 11);
      for (int r = 0; r < n && r < 11; r++) begin
         checkOutput($sformatf("%s_r%0d", pfx, r), useB ? beatsB[r] : beatsA[r], EXP128[r]);
         checkOutput($sformatf("%s_idx%0d", pfx, r), useB ? idxB[r] : idxA[r], r);
         checkOutput($sformatf("%s_last%0d", pfx, r), useB ? lastB[r] : lastA[r], r == 10);
      end
   endtask

   initial begin
      int fv, la, ia;
      rst_n = 1'b0;
      startA = 1'b0; abortA = 1'b0; keyLenA = KEY_LEN_128; keyA = '0;
      startB = 1'b0; abortB = 1'b0; keyLenB = KEY_LEN_128; keyB = '0;
      randReadyA = 1'b0;
      randReadyB = 1'b0;

      // Reset state.
      #1;
      checkOutput("rstBusy",  busyA, 1'b0);
      checkOutput("rstErr",   errA, 1'b0);
      checkOutput("rstValid", rkA.rk_valid, 1'b0);
      checkOutput("rstData",  rkA.rk_data, 128'h0);
      checkOutput("rstIndex", rkA.rk_index, 4'h0);
      checkOutput("rstLast",  rkA.rk_last, 1'b0);
      checkOutput("rstValidB", rkB.rk_valid, 1'b0);
      #22;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // AES-128, always ready, with an ignored start in the middle.
      clearBeats();
      applyStimulus(1'b0, KEY_LEN_128, KEY128);
      runUntilIdle(1'b0, 200, 10, fv, la, ia);
      checkOutput("lat128First", fv, 4);
      checkOutput("lat128Last", la, 44);
      checkOutput("lat128Idle", ia, 45);
      checkBeats128(1'b0, "a128");

      // AES-192.
      clearBeats();
      applyStimulus(1'b0, KEY_LEN_192, KEY192);
      runUntilIdle(1'b0, 200, -1, fv, la, ia);
      checkOutput("a192_count", beatsA.size(), 13);
      checkOutput("a192_r0",  beatA(0),  128'h8e73b0f7da0e6452c810f32b809079e5);
      checkOutput("a192_r1",  beatA(1),  128'h62f8ead2522c6b7bfe0c91f72402f5a5);
      checkOutput("a192_r12", beatA(12), 128'he98ba06f448c773c8ecc720401002202);
      checkOutput("lat192Last", la, 52);

      // AES-256.
      clearBeats();
      applyStimulus(1'b0, KEY_LEN_256, KEY256);
      runUntilIdle(1'b0, 200, -1, fv, la, ia);
      checkOutput("a256_count", beatsA.size(), 15);
      checkOutput("a256_r0",  beatA(0),  128'h603deb1015ca71be2b73aef0857d7781);
      checkOutput("a256_r1",  beatA(1),  128'h1f352c073b6108d72d9810a30914dff4);
      checkOutput("a256_r2",  beatA(2),  128'h9ba354118e6925afa51a8b5f2067fcde);
      checkOutput("a256_r14", beatA(14), 128'hfe4890d1e6188d0b046df344706c631e);
      checkOutput("lat256Last", la, 60);

      // Illegal key_len, and a key longer than instance B supports.
      applyStimulus(1'b0, KEY_LEN_ILLEGAL, KEY256);
      checkOutput("errPulseA", errA, 1'b1);
      checkOutput("errBusyA", busyA, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("errClearA", errA, 1'b0);
      checkOutput("errIdleA", busyA, 1'b0);
      applyStimulus(1'b1, KEY_LEN_192, KEY192);
      checkOutput("errPulseB", errB, 1'b1);
      checkOutput("errBusyB", busyB, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("errClearB", errB, 1'b0);

      // Backpressure on both FIFO depths.
      clearBeats();
      randReadyA = 1'b1;
      applyStimulus(1'b0, KEY_LEN_128, KEY128);
      runUntilIdle(1'b0, 2000, -1, fv, la, ia);
      randReadyA = 1'b0;
      checkBeats128(1'b0, "bpA");
      randReadyB = 1'b1;
      applyStimulus(1'b1, KEY_LEN_128, KEY128);
      runUntilIdle(1'b1, 2000, -1, fv, la, ia);
      randReadyB = 1'b0;
      checkBeats128(1'b1, "bpB");

      // Abort after the fifth beat, then a clean restart.
      @(posedge clk);
      #1;
      clearBeats();
      applyStimulus(1'b0, KEY_LEN_128, KEY128);
      for (int n = 0; n < 100 && beatsA.size() < 5; n++) begin
         @(posedge clk);
         #1;
      end
      checkOutput("abortReach", beatsA.size() >= 5, 1'b1);
      abortA = 1'b1;
      @(posedge clk);
      #1;
      abortA = 1'b0;
      checkOutput("abortValid", rkA.rk_valid, 1'b0);
      checkOutput("abortBusy", busyA, 1'b0);
      clearBeats();
      applyStimulus(1'b0, KEY_LEN_128, KEY128);
      runUntilIdle(1'b0, 200, -1, fv, la, ia);
      checkBeats128(1'b0, "restart");

      // Asynchronous reset in the middle of generation.
      applyStimulus(1'b0, KEY_LEN_256, KEY256);
      repeat (10) @(posedge clk);
      #3;
      checkOutput("preRstBusy", busyA, 1'b1);
      rst_n = 1'b0;
      #1;
      checkOutput("asyncBusy",  busyA, 1'b0);
      checkOutput("asyncErr",   errA, 1'b0);
      checkOutput("asyncValid", rkA.rk_valid, 1'b0);
      checkOutput("asyncData",  rkA.rk_data, 128'h0);
      checkOutput("asyncIndex", rkA.rk_index, 4'h0);
      checkOutput("asyncLast",  rkA.rk_last, 1'b0);
      #10;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
